// File: rtl/stg_mo_dseq.sv
// Data-memory beat sequencer: splits each 24/48-bit load or store into one or
// two 24-bit memory beats and reassembles 48-bit load results.
module stg_mo_dseq #(
  parameter int ADDR_W = 48,
  parameter int WORD_W = 24
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_req,
  input  logic                  iw_we,
  input  logic                  iw_is48,
  input  logic [ADDR_W-1:0]     iw_addr,
  input  logic [2*WORD_W-1:0]   iw_wdata,
  output logic                  ow_stall,
  output logic [2*WORD_W-1:0]   or_rdata,
  output logic                  or_rvalid,
  output logic                  ow_mem_en,
  output logic                  ow_mem_we,
  output logic [ADDR_W-1:0]     ow_mem_addr,
  output logic [WORD_W-1:0]     ow_mem_wdata,
  input  logic [WORD_W-1:0]     iw_mem_rdata
);

  // Handshake: a request is taken on the rising edge when iw_req=1 and
  // ow_stall=0; while ow_stall=1 the upstream must hold its request.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic                  is48_q, is48_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2*WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]     rlo_q, rlo_d;
  logic [2*WORD_W-1:0]   rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    is48_d       = is48_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rlo_d        = rlo_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    ow_mem_en    = 1'b0;
    ow_mem_we    = 1'b0;
    ow_mem_addr  = '0;
    ow_mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        if (iw_req) begin
          we_d    = iw_we;
          is48_d  = iw_is48;
          addr_d  = iw_addr;
          wdata_d = iw_wdata;
          state_d = S_LO;
        end
      end
      S_LO: begin
        ow_mem_en    = 1'b1;
        ow_mem_we    = we_q;
        ow_mem_addr  = addr_q;
        ow_mem_wdata = wdata_q[WORD_W-1:0];
        if (is48_q)     state_d = S_HI;
        else if (!we_q) state_d = S_WAIT;
        else            state_d = S_IDLE;
      end
      S_HI: begin
        // Address wraps modulo 2^ADDR_W at the top of memory.
        ow_mem_en    = 1'b1;
        ow_mem_we    = we_q;
        ow_mem_addr  = addr_q + ADDR_W'(1);
        ow_mem_wdata = wdata_q[2*WORD_W-1:WORD_W];
        if (!we_q) rlo_d = iw_mem_rdata;
        state_d = we_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (is48_q) rdata_d = {iw_mem_rdata, rlo_q};
        else        rdata_d = {{WORD_W{1'b0}}, iw_mem_rdata};
        rvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      is48_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rlo_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      is48_q   <= is48_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rlo_q    <= rlo_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign ow_stall  = (state_q != S_IDLE);
  assign or_rdata  = rdata_q;
  assign or_rvalid = rvalid_q;

endmodule

// File: tb/tb_stg_mo_dseq.sv
// Scoreboarded bench for stg_mo_dseq: a driver pushes expected beats and load
// results per request; a negedge monitor pops and compares what the DUT shows.
module tb_stg_mo_dseq;

  localparam int AW = 48;
  localparam int WW = 24;

  logic            iw_clk = 1'b0;
  logic            iw_rst;
  logic            iw_req;
  logic            iw_we;
  logic            iw_is48;
  logic [AW-1:0]   iw_addr;
  logic [2*WW-1:0] iw_wdata;
  logic            ow_stall;
  logic [2*WW-1:0] or_rdata;
  logic            or_rvalid;
  logic            ow_mem_en;
  logic            ow_mem_we;
  logic [AW-1:0]   ow_mem_addr;
  logic [WW-1:0]   ow_mem_wdata;
  logic [WW-1:0]   iw_mem_rdata = '0;

  stg_mo_dseq #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .iw_clk       (iw_clk),
    .iw_rst       (iw_rst),
    .iw_req       (iw_req),
    .iw_we        (iw_we),
    .iw_is48      (iw_is48),
    .iw_addr      (iw_addr),
    .iw_wdata     (iw_wdata),
    .ow_stall     (ow_stall),
    .or_rdata     (or_rdata),
    .or_rvalid    (or_rvalid),
    .ow_mem_en    (ow_mem_en),
    .ow_mem_we    (ow_mem_we),
    .ow_mem_addr  (ow_mem_addr),
    .ow_mem_wdata (ow_mem_wdata),
    .iw_mem_rdata (iw_mem_rdata)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 iw_clk = ~iw_clk;

  logic [31:0] cyc = '0;
  always @(posedge iw_clk) cyc <= cyc + 32'd1;

  // ---------------- memories ----------------
  logic [WW-1:0] env_mem [logic [AW-1:0]];
  logic [WW-1:0] mdl_mem [logic [AW-1:0]];

  function automatic logic [WW-1:0] fill(input logic [AW-1:0] a);
    return a[WW-1:0] ^ 24'hA5C3E1;
  endfunction

  function automatic logic [WW-1:0] env_rd(input logic [AW-1:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return fill(a);
  endfunction

  function automatic logic [WW-1:0] mdl_rd(input logic [AW-1:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return fill(a);
  endfunction

  // Registered single-port memory driven by the DUT.
  always @(posedge iw_clk) begin
    if (ow_mem_en) begin
      if (ow_mem_we) env_mem[ow_mem_addr] = ow_mem_wdata;
      else           iw_mem_rdata <= env_rd(ow_mem_addr);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic          we;
    logic [WW-1:0] wd;
    logic [31:0]   cyc;
  } beat_t;

  typedef struct {
    logic [2*WW-1:0] data;
    logic [31:0]     cyc;
  } rd_t;

  beat_t           beat_q[$];
  rd_t             rd_q[$];
  logic [31:0]     busy_end = '0;
  logic [2*WW-1:0] hold_exp = '0;
  logic            mon_on = 1'b0;
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge iw_clk) begin
    if (mon_on) begin
      chk("stall", 80'(ow_stall), 80'(cyc < busy_end));
      if (ow_mem_en) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 80'(ow_mem_addr), 80'hDEAD);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_addr", 80'(ow_mem_addr), 80'(b.a));
          chk("beat_we", 80'(ow_mem_we), 80'(b.we));
          chk("beat_wdata", 80'(ow_mem_wdata), 80'(b.wd));
          chk("beat_cycle", 80'(cyc), 80'(b.cyc));
        end
      end else begin
        chk("idle_bus", {7'd0, ow_mem_we, ow_mem_addr, ow_mem_wdata}, 80'd0);
      end
      if (or_rvalid) begin
        if (rd_q.size() == 0) begin
          chk("rvalid_unexpected", 80'(or_rdata), 80'hDEAD);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          chk("rdata", 80'(or_rdata), 80'(r.data));
          chk("rvalid_cycle", 80'(cyc), 80'(r.cyc));
          hold_exp = r.data;
        end
      end
      chk("rdata_hold", 80'(or_rdata), 80'(hold_exp));
    end
  end

  // ---------------- driver ----------------
  // Called just after a negedge; returns just after the negedge of cycle 1.
  task automatic issue(input logic we, input logic is48, input logic [AW-1:0] a,
                       input logic [2*WW-1:0] wd);
    int guard;
    logic [31:0] acc;
    iw_req   = 1'b1;
    iw_we    = we;
    iw_is48  = is48;
    iw_addr  = a;
    iw_wdata = wd;
    guard = 0;
    while (cyc < busy_end && guard < 20) begin
      @(negedge iw_clk);
      guard++;
    end
    if (guard >= 20) chk("accept_timeout", 80'(guard), 80'd0);
    @(posedge iw_clk);
    acc = cyc;
    beat_q.push_back('{a: a, we: we, wd: wd[WW-1:0], cyc: acc + 32'd1});
    if (is48) beat_q.push_back('{a: a + 48'd1, we: we, wd: wd[2*WW-1:WW], cyc: acc + 32'd2});
    if (we) begin
      mdl_mem[a] = wd[WW-1:0];
      if (is48) mdl_mem[a + 48'd1] = wd[2*WW-1:WW];
      busy_end = acc + (is48 ? 32'd3 : 32'd2);
    end else begin
      if (is48) rd_q.push_back('{data: {mdl_rd(a + 48'd1), mdl_rd(a)}, cyc: acc + 32'd4});
      else      rd_q.push_back('{data: {24'h0, mdl_rd(a)}, cyc: acc + 32'd3});
      busy_end = acc + (is48 ? 32'd4 : 32'd3);
    end
    @(negedge iw_clk);
  endtask

  task automatic gap(input int n);
    iw_req = 1'b0;
    repeat (n) @(negedge iw_clk);
  endtask

  task automatic wait_idle();
    int guard;
    iw_req = 1'b0;
    guard = 0;
    while (cyc < busy_end && guard < 20) begin
      @(negedge iw_clk);
      guard++;
    end
    if (guard >= 20) chk("idle_timeout", 80'(guard), 80'd0);
    @(negedge iw_clk);
  endtask

  // Assert reset for one edge from the current negedge; anything in flight is dropped.
  task automatic do_reset();
    iw_req = 1'b0;
    iw_rst = 1'b1;
    @(posedge iw_clk);
    beat_q.delete();
    rd_q.delete();
    hold_exp = '0;
    busy_end = cyc + 32'd1;
    @(negedge iw_clk);
    iw_rst = 1'b0;
    chk("rst_stall", 80'(ow_stall), 80'd0);
    chk("rst_rvalid", 80'(or_rvalid), 80'd0);
    chk("rst_rdata", 80'(or_rdata), 80'd0);
    chk("rst_mem_en", 80'(ow_mem_en), 80'd0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 2));
    return 48'($urandom_range(0, 31));
  endfunction

  initial begin
    iw_rst   = 1'b1;
    iw_req   = 1'b0;
    iw_we    = 1'b0;
    iw_is48  = 1'b0;
    iw_addr  = '0;
    iw_wdata = '0;
    repeat (2) @(posedge iw_clk);
    @(negedge iw_clk);
    iw_rst = 1'b0;
    chk("reset_stall", 80'(ow_stall), 80'd0);
    chk("reset_rvalid", 80'(or_rvalid), 80'd0);
    chk("reset_rdata", 80'(or_rdata), 80'd0);
    chk("reset_bus", {6'd0, ow_mem_en, ow_mem_we, ow_mem_addr, ow_mem_wdata}, 80'd0);
    busy_end = cyc;
    mon_on = 1'b1;

    // Directed: 48-bit store/load, 24-bit store/load, wrap, held request.
    issue(1'b1, 1'b1, 48'd20, 48'hCAFEBE_987654);
    issue(1'b0, 1'b1, 48'd20, 48'h111111_222222);
    gap(2);
    issue(1'b1, 1'b0, 48'd5, 48'h000000_123456);
    issue(1'b0, 1'b0, 48'd5, 48'h0F0F0F_F0F0F0);
    issue(1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 48'hAAAAAA_555555);
    issue(1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 48'd0);
    issue(1'b0, 1'b1, 48'd20, 48'd0);
    issue(1'b0, 1'b1, 48'd100, 48'd0);
    wait_idle();
    chk("mem20", 80'(env_rd(48'd20)), 80'h987654);
    chk("mem21", 80'(env_rd(48'd21)), 80'hCAFEBE);
    chk("mem5", 80'(env_rd(48'd5)), 80'h123456);
    chk("mem6_untouched", 80'(env_rd(48'd6)), 80'(fill(48'd6)));
    chk("mem_top", 80'(env_rd(48'hFFFF_FFFF_FFFF)), 80'h555555);
    chk("mem_wrap0", 80'(env_rd(48'd0)), 80'hAAAAAA);

    // Reset during the HI beat of a 48-bit store, then a fresh 24-bit load.
    issue(1'b1, 1'b1, 48'd60, 48'h13579B_2468AC);
    iw_req = 1'b0;
    @(negedge iw_clk);
    do_reset();
    repeat (2) @(negedge iw_clk);
    issue(1'b0, 1'b0, 48'd60, 48'd0);
    wait_idle();

    // Reset during the HI beat of a 48-bit load: its result must never appear.
    issue(1'b0, 1'b1, 48'd30, 48'd0);
    iw_req = 1'b0;
    @(negedge iw_clk);
    do_reset();
    repeat (4) @(negedge iw_clk);

    // Randomized traffic, with both held and idle-gapped requests.
    for (int i = 0; i < 150; i++) begin
      logic          rwe;
      logic          r48;
      logic [AW-1:0] ra;
      logic [2*WW-1:0] rwd;
      rwe = 1'($urandom_range(0, 1));
      r48 = 1'($urandom_range(0, 1));
      ra  = rand_addr();
      rwd = {16'($urandom), 32'($urandom)};
      issue(rwe, r48, ra, rwd);
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
    end
    wait_idle();
    repeat (3) @(negedge iw_clk);
    chk("beat_q_empty", 80'(beat_q.size()), 80'd0);
    chk("rd_q_empty", 80'(rd_q.size()), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
